// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: access-size encodings, memory-stage
// state encoding and byte-lane helpers used by the load/store path.
package cpu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mau_state_t;

    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] a
    );
        logic r;
        r = 1'b0;
        unique case (size)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = a[0];
            default: r = |a;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] lane_strobe(
        input logic [1:0] size,
        input logic [1:0] a
    );
        logic [3:0] s;
        s = 4'hF;
        unique case (size)
            SZ_BYTE: s = 4'b0001 << a;
            SZ_HALF: s = 4'b0011 << a;
            default: s = 4'hF;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] lane_wdata(
        input logic [1:0]  size,
        input logic [31:0] d
    );
        logic [31:0] w;
        w = d;
        unique case (size)
            SZ_BYTE: w = {4{d[7:0]}};
            SZ_HALF: w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data lane select with sign/zero extension; purely combinational
// so it can also sit on the instruction-fetch byte path.
module load_align
    import cpu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] result
);

    logic [31:0] lane;

    always_comb begin
        lane   = rdata >> {a, 3'b000};
        result = lane;
        unique case (size)
            SZ_BYTE: result = {{24{~uns & lane[7]}}, lane[7:0]};
            SZ_HALF: result = {{16{~uns & lane[15]}}, lane[15:0]};
            default: result = lane;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one outstanding req/ack access to data
// memory, store lane steering, load alignment and pipeline stall.
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic              data_read,
    output logic [31:0]       data_result,
    output logic              misalign_err
);

    mau_state_t  state, state_nx;
    logic        accept;
    logic        mis;
    logic        op_read;
    logic        err_q;
    logic [1:0]  a_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] aligned;

    assign accept = (state == ST_IDLE) & ex_valid
                  & (ex_mem_read | ex_mem_write);
    assign mis    = is_misaligned(ex_size, ex_addr[1:0]);

    load_align u_align (
        .rdata  (mem_rdata),
        .a      (a_q),
        .size   (size_q),
        .uns    (uns_q),
        .result (aligned)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (accept) state_nx = mis ? ST_DONE : ST_BUSY;
            ST_BUSY: if (mem_ack) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_read     <= 1'b0;
            err_q       <= 1'b0;
            a_q         <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            data_result <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_read <= ex_mem_read;
                err_q   <= mis;
                a_q     <= ex_addr[1:0];
                size_q  <= ex_size;
                uns_q   <= ex_unsigned;
                // A misaligned access never reaches memory; keep the bus quiet
                if (mis) begin
                    data_result <= '0;
                    mem_we      <= 1'b0;
                    mem_wdata   <= '0;
                    mem_wstrb   <= '0;
                end else begin
                    mem_we    <= ~ex_mem_read;
                    mem_addr  <= {ex_addr[ADDR_W-1:2], 2'b00};
                    mem_wdata <= ex_mem_read ? 32'h0
                               : lane_wdata(ex_size, ex_wdata);
                    mem_wstrb <= ex_mem_read ? 4'h0
                               : lane_strobe(ex_size, ex_addr[1:0]);
                end
            end
            if ((state == ST_BUSY) && mem_ack && op_read)
                data_result <= aligned;
        end
    end

    assign mem_req      = (state == ST_BUSY);
    assign stall        = accept | (state == ST_BUSY);
    assign wb_valid     = (state == ST_DONE);
    assign data_read    = (state == ST_DONE) & op_read & ~err_q;
    assign misalign_err = (state == ST_DONE) & err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed loads/stores with
// hand-computed results, checked by a monitor on wb_valid.
module tb_mem_access_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_read, ex_mem_write;
    logic [31:0] ex_addr, ex_wdata;
    logic [1:0]  ex_size;
    logic        ex_unsigned;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid, data_read, misalign_err;
    logic [31:0] data_result;

    typedef struct packed {
        logic        dr;
        logic        err;
        logic [31:0] res;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .ex_size      (ex_size),
        .ex_unsigned  (ex_unsigned),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .wb_valid     (wb_valid),
        .data_read    (data_read),
        .data_result  (data_result),
        .misalign_err (misalign_err)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every write-back pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wb_unexpected: got wb_valid 1 expected 0");
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                chk("wb_data_read", 32'(data_read), 32'(e.dr));
                chk("wb_misalign", 32'(misalign_err), 32'(e.err));
                chk("wb_result", data_result, e.res);
            end
        end
    end

    task automatic present(input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] sz, input logic u);
        ex_valid     = 1'b1;
        ex_mem_read  = rd;
        ex_mem_write = wr;
        ex_addr      = a;
        ex_wdata     = wd;
        ex_size      = sz;
        ex_unsigned  = u;
    endtask

    task automatic idle_ex();
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at the DONE negedge
    task automatic do_op(input string nm, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic u,
                         input int dly, input logic [31:0] rdata,
                         input logic [31:0] e_addr, input logic [31:0] e_wd,
                         input logic [3:0] e_strb, input logic [31:0] e_res);
        present(rd, wr, a, wd, sz, u);
        exp_q.push_back('{dr: rd, err: 1'b0, res: e_res});
        #1 chk({nm, "_stall_accept"}, 32'(stall), 32'd1);
        @(negedge clk);
        idle_ex();
        chk({nm, "_req"}, 32'(mem_req), 32'd1);
        chk({nm, "_we"}, 32'(mem_we), 32'(!rd));
        chk({nm, "_addr"}, mem_addr, e_addr);
        chk({nm, "_wdata"}, mem_wdata, e_wd);
        chk({nm, "_wstrb"}, 32'(mem_wstrb), 32'(e_strb));
        for (int i = 0; i < dly; i++) begin
            chk({nm, "_stall_busy"}, 32'(stall), 32'd1);
            @(negedge clk);
            chk({nm, "_req_hold"}, 32'(mem_req), 32'd1);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
        chk({nm, "_wb_pulse"}, 32'(wb_valid), 32'd1);
        chk({nm, "_stall_done"}, 32'(stall), 32'd0);
        chk({nm, "_req_done"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle_ex();
        ex_addr     = '0;
        ex_wdata    = '0;
        ex_size     = SZ_WORD;
        ex_unsigned = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_wb", 32'(wb_valid), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_result", data_result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op("ldw", 1, 0, 32'h100, 0, SZ_WORD, 0, 3, 32'hDEADBEEF,
              32'h100, 32'h0, 4'h0, 32'hDEADBEEF);
        @(negedge clk);
        chk("ldw_hold", data_result, 32'hDEADBEEF);
        do_op("lbs", 1, 0, 32'h103, 0, SZ_BYTE, 0, 1, 32'h80123456,
              32'h100, 32'h0, 4'h0, 32'hFFFFFF80);
        @(negedge clk);
        do_op("lbu", 1, 0, 32'h103, 0, SZ_BYTE, 1, 0, 32'h80123456,
              32'h100, 32'h0, 4'h0, 32'h00000080);
        @(negedge clk);
        do_op("sh", 0, 1, 32'h202, 32'hFFFF1234, SZ_HALF, 0, 2, 0,
              32'h200, 32'h12341234, 4'b1100, 32'h00000080);
        @(negedge clk);
        do_op("sb", 0, 1, 32'h301, 32'h000000AB, SZ_BYTE, 0, 0, 0,
              32'h300, 32'hABABABAB, 4'b0010, 32'h00000080);
        @(negedge clk);
        do_op("lhs", 1, 0, 32'h102, 0, SZ_HALF, 0, 1, 32'h80017FFF,
              32'h100, 32'h0, 4'h0, 32'hFFFF8001);
        @(negedge clk);
        do_op("lhu", 1, 1, 32'h102, 0, SZ_HALF, 1, 0, 32'h80017FFF,
              32'h100, 32'h0, 4'h0, 32'h00008001);
        @(negedge clk);
        do_op("sw", 0, 1, 32'h400, 32'hCAFEF00D, SZ_WORD, 0, 1, 0,
              32'h400, 32'hCAFEF00D, 4'hF, 32'h00008001);
        @(negedge clk);
        do_op("ld11", 1, 0, 32'h10, 0, 2'b11, 0, 0, 32'h11223344,
              32'h10, 32'h0, 4'h0, 32'h11223344);
        @(negedge clk);

        // Misaligned word load
        present(1, 0, 32'h101, 0, SZ_WORD, 0);
        exp_q.push_back('{dr: 1'b0, err: 1'b1, res: 32'h0});
        @(negedge clk);
        idle_ex();
        chk("mis_req", 32'(mem_req), 32'd0);
        chk("mis_wb", 32'(wb_valid), 32'd1);
        @(negedge clk);
        chk("mis_req_after", 32'(mem_req), 32'd0);

        // Non-memory instruction passes through
        present(0, 0, 32'h104, 0, SZ_WORD, 0);
        #1 chk("alu_stall", 32'(stall), 32'd0);
        @(negedge clk);
        idle_ex();
        chk("alu_req", 32'(mem_req), 32'd0);

        // Reset in the second BUSY cycle abandons the access
        present(1, 0, 32'h100, 0, SZ_WORD, 0);
        @(negedge clk);
        idle_ex();
        @(negedge clk);
        chk("rab_req_busy", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rab_req", 32'(mem_req), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h77777777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rab_no_wb", 32'(wb_valid), 32'd0);
            chk("rab_no_req", 32'(mem_req), 32'd0);
        end
        mem_ack = 1'b0;
        chk("rab_result", data_result, 32'd0);

        // Back-to-back loads, ack in the first BUSY cycle
        do_op("bb1", 1, 0, 32'h500, 0, SZ_WORD, 0, 0, 32'h01020304,
              32'h500, 32'h0, 4'h0, 32'h01020304);
        @(negedge clk);
        chk("bb_idle_req", 32'(mem_req), 32'd0);
        do_op("bb2", 1, 0, 32'h506, 0, SZ_HALF, 0, 0, 32'hA5B6C7D8,
              32'h504, 32'h0, 4'h0, 32'hFFFFA5B6);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
